// File: rtl/id_ex_stage.sv
// ID/EX pipeline register with operand forwarding, ALU source selection and
// load-use hazard detection for the execute-stage ALU.
//
// Flow control: this stage has no valid/ready handshake. stall holds every
// register, flush loads a bubble, and load_use tells IF/ID to hold while the
// stage inserts a bubble itself. The per-edge priority is
// flush > stall > load_use > capture.
module id_ex_stage #(
    parameter int DW = 32,
    parameter int AW = 5
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          stall,
    input  logic          flush,
    input  logic          id_valid,
    input  logic [AW-1:0] id_rs_addr,
    input  logic [AW-1:0] id_rt_addr,
    input  logic [AW-1:0] id_rd_addr,
    input  logic [DW-1:0] id_rs_data,
    input  logic [DW-1:0] id_rt_data,
    input  logic [DW-1:0] id_imm,
    input  logic [4:0]    id_shamt,
    input  logic [2:0]    id_alu_op,
    input  logic [1:0]    id_op_sel,
    input  logic          id_reg_write,
    input  logic          id_mem_read,
    input  logic          id_rs_used,
    input  logic          id_rt_used,
    input  logic          exm_wr_en,
    input  logic [AW-1:0] exm_wr_addr,
    input  logic [DW-1:0] exm_wr_data,
    input  logic          mwb_wr_en,
    input  logic [AW-1:0] mwb_wr_addr,
    input  logic [DW-1:0] mwb_wr_data,
    output logic [DW-1:0] alu_a,
    output logic [DW-1:0] alu_b,
    output logic [2:0]    alu_op,
    output logic          ex_valid,
    output logic          ex_reg_write,
    output logic          ex_mem_read,
    output logic [AW-1:0] ex_rd_addr,
    output logic [DW-1:0] ex_store_data,
    output logic          load_use
);

    // Operand-form encodings of id_op_sel
    localparam logic [1:0] SEL_RR    = 2'b00;
    localparam logic [1:0] SEL_RI    = 2'b01;
    localparam logic [1:0] SEL_SHAMT = 2'b10;
    localparam logic [1:0] SEL_SHVAR = 2'b11;

    // Registered operand state (control state is held in the output regs)
    logic [AW-1:0] rs_addr_q;
    logic [AW-1:0] rt_addr_q;
    logic [DW-1:0] rs_data_q;
    logic [DW-1:0] rt_data_q;
    logic [DW-1:0] imm_q;
    logic [4:0]    shamt_q;
    logic [1:0]    op_sel_q;

    logic [DW-1:0] frs;
    logic [DW-1:0] frt;
    logic          rs_hit;
    logic          rt_hit;

    // Load-use: a load in EX whose destination is read by the instruction in ID.
    // Register 0 never creates a dependency. Independent of stall.
    assign rs_hit   = id_rs_used && (id_rs_addr == ex_rd_addr);
    assign rt_hit   = id_rt_used && (id_rt_addr == ex_rd_addr);
    assign load_use = ex_valid && ex_mem_read && (ex_rd_addr != '0) &&
                      id_valid && (rs_hit || rt_hit);

    // Stage register update: flush > stall > load_use/invalid bubble > capture.
    // A bubble is all-zero state, which yields add with zero operands and no
    // register or memory side effects.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ex_valid     <= 1'b0;
            ex_reg_write <= 1'b0;
            ex_mem_read  <= 1'b0;
            alu_op       <= 3'b000;
            ex_rd_addr   <= '0;
            rs_addr_q    <= '0;
            rt_addr_q    <= '0;
            rs_data_q    <= '0;
            rt_data_q    <= '0;
            imm_q        <= '0;
            shamt_q      <= '0;
            op_sel_q     <= SEL_RR;
        end else if (flush || (!stall && (load_use || !id_valid))) begin
            ex_valid     <= 1'b0;
            ex_reg_write <= 1'b0;
            ex_mem_read  <= 1'b0;
            alu_op       <= 3'b000;
            ex_rd_addr   <= '0;
            rs_addr_q    <= '0;
            rt_addr_q    <= '0;
            rs_data_q    <= '0;
            rt_data_q    <= '0;
            imm_q        <= '0;
            shamt_q      <= '0;
            op_sel_q     <= SEL_RR;
        end else if (!stall) begin
            ex_valid     <= 1'b1;
            ex_reg_write <= id_reg_write;
            ex_mem_read  <= id_mem_read;
            alu_op       <= id_alu_op;
            ex_rd_addr   <= id_rd_addr;
            rs_addr_q    <= id_rs_addr;
            rt_addr_q    <= id_rt_addr;
            rs_data_q    <= id_rs_data;
            rt_data_q    <= id_rt_data;
            imm_q        <= id_imm;
            shamt_q      <= id_shamt;
            op_sel_q     <= id_op_sel;
        end
    end

    // Forwarding: EX/MEM beats MEM/WB; register 0 always reads as captured.
    always_comb begin
        frs = rs_data_q;
        if (rs_addr_q != '0) begin
            if (exm_wr_en && (exm_wr_addr == rs_addr_q)) begin
                frs = exm_wr_data;
            end else if (mwb_wr_en && (mwb_wr_addr == rs_addr_q)) begin
                frs = mwb_wr_data;
            end
        end
        frt = rt_data_q;
        if (rt_addr_q != '0) begin
            if (exm_wr_en && (exm_wr_addr == rt_addr_q)) begin
                frt = exm_wr_data;
            end else if (mwb_wr_en && (mwb_wr_addr == rt_addr_q)) begin
                frt = mwb_wr_data;
            end
        end
    end

    // ALU source selection; shift forms put the shifted value (rt) on A.
    always_comb begin
        alu_a         = frs;
        alu_b         = frt;
        ex_store_data = frt;
        case (op_sel_q)
            SEL_RR: begin
                alu_a = frs;
                alu_b = frt;
            end
            SEL_RI: begin
                alu_a = frs;
                alu_b = imm_q;
            end
            SEL_SHAMT: begin
                alu_a = frt;
                alu_b = {{(DW-5){1'b0}}, shamt_q};
            end
            SEL_SHVAR: begin
                alu_a = frt;
                alu_b = {{(DW-5){1'b0}}, frs[4:0]};
            end
            default: begin
                alu_a = frs;
                alu_b = frt;
            end
        endcase
    end

endmodule
